// File: rtl/sayeh_ctrl_pkg.sv
// sayeh_ctrl_pkg: op codes and FSM state encodings shared by the Sayeh controller blocks
package sayeh_ctrl_pkg;
  localparam logic [2:0] OP_BRZ  = 3'b000;
  localparam logic [2:0] OP_BRNZ = 3'b001;
  localparam logic [2:0] OP_BRC  = 3'b010;
  localparam logic [2:0] OP_BRNC = 3'b011;
  localparam logic [2:0] OP_SCF  = 3'b100;
  localparam logic [2:0] OP_CCF  = 3'b101;
  localparam logic [2:0] OP_SZF  = 3'b110;
  localparam logic [2:0] OP_CZF  = 3'b111;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_FLAG    = 2'd3;
endpackage

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: resolves C/Z branches (taken, next_pc) and issues C/Z set/reset strobes; in: req/op/pc/offset/srload_pending/cflag/zflag, out: busy/ack/taken/next_pc/strobes
module flag_branch_unit
  import sayeh_ctrl_pkg::*;
#(
  parameter int AW = 16,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [2:0]    op,
  input  logic [AW-1:0] pc,
  input  logic [OW-1:0] offset,
  input  logic          srload_pending,
  input  logic          cflag,
  input  logic          zflag,
  output logic          busy,
  output logic          ack,
  output logic          taken,
  output logic [AW-1:0] next_pc,
  output logic          cset,
  output logic          creset,
  output logic          zset,
  output logic          zreset
);
  logic [1:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [AW-1:0] pc_q, pc_d, next_pc_q, next_pc_d;
  logic [OW-1:0] off_q, off_d;
  logic ack_q, ack_d, taken_q, taken_d;
  logic [3:0] strb_q, strb_d;
  logic cond;
  logic [AW-1:0] target;
  assign cond = (op_q[1] ? cflag : zflag) ^ op_q[0];
  assign target = pc_q + {{(AW-OW){off_q[OW-1]}}, off_q};
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    pc_d = pc_q;
    off_d = off_q;
    next_pc_d = next_pc_q;
    ack_d = 1'b0;
    taken_d = 1'b0;
    strb_d = '0;
    case (state_q)
      ST_IDLE: if (req) begin
        op_d = op[1:0];
        pc_d = pc;
        off_d = offset;
        state_d = op[2] ? ST_FLAG : (srload_pending ? ST_SETTLE : ST_RESOLVE);
      end
      ST_SETTLE: state_d = ST_RESOLVE;
      ST_RESOLVE: begin
        ack_d = 1'b1;
        taken_d = cond;
        next_pc_d = cond ? target : pc_q + AW'(1);
        state_d = ST_IDLE;
      end
      default: if (!srload_pending) begin
        ack_d = 1'b1;
        strb_d = 4'b0001 << op_q;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q <= '0;
      pc_q <= '0;
      off_q <= '0;
      next_pc_q <= '0;
      ack_q <= 1'b0;
      taken_q <= 1'b0;
      strb_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      pc_q <= pc_d;
      off_q <= off_d;
      next_pc_q <= next_pc_d;
      ack_q <= ack_d;
      taken_q <= taken_d;
      strb_q <= strb_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign ack = ack_q;
  assign taken = taken_q;
  assign next_pc = next_pc_q;
  assign {zreset, zset, creset, cset} = strb_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed self-checking bench for flag_branch_unit
module tb_flag_branch_unit;
  import sayeh_ctrl_pkg::*;
  logic clk = 0, rst = 1, req = 0, srload_pending = 0, cflag = 0, zflag = 0;
  logic [2:0] op = '0;
  logic [15:0] pc = '0;
  logic [7:0] offset = '0;
  logic busy, ack, taken, cset, creset, zset, zreset;
  logic [15:0] next_pc;
  int checks = 0, failures = 0;
  flag_branch_unit #(.AW(16), .OW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .pc(pc), .offset(offset),
    .srload_pending(srload_pending), .cflag(cflag), .zflag(zflag),
    .busy(busy), .ack(ack), .taken(taken), .next_pc(next_pc),
    .cset(cset), .creset(creset), .zset(zset), .zreset(zreset)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic b, input logic a, input logic t,
                         input logic [15:0] np, input logic [3:0] s);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".ack"}, {31'd0, ack}, {31'd0, a});
    chk({tag, ".taken"}, {31'd0, taken}, {31'd0, t});
    chk({tag, ".next_pc"}, {16'd0, next_pc}, {16'd0, np});
    chk({tag, ".strobes"}, {28'd0, zreset, zset, creset, cset}, {28'd0, s});
  endtask
  initial begin
    step();
    step();
    chk_out("reset", 0, 0, 0, 16'h0000, 4'b0000);
    chk("reset.state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    rst = 0;
    // BRZ taken, negative offset
    req = 1; op = OP_BRZ; pc = 16'h0010; offset = 8'hFE; zflag = 1;
    step();
    req = 0;
    chk_out("brz.e0", 1, 0, 0, 16'h0000, 4'b0000);
    step();
    chk_out("brz.e1", 0, 1, 1, 16'h000E, 4'b0000);
    step();
    chk_out("brz.e2", 0, 0, 0, 16'h000E, 4'b0000);
    // BRNC not taken, pc wraps
    req = 1; op = OP_BRNC; pc = 16'hFFFF; offset = 8'h10; cflag = 1;
    step();
    req = 0;
    step();
    chk_out("brnc.ack", 0, 1, 0, 16'h0000, 4'b0000);
    // BRC with pending load; flag lands at the request edge
    req = 1; op = OP_BRC; pc = 16'h0100; offset = 8'h05; cflag = 0; srload_pending = 1;
    step();
    req = 0; srload_pending = 0; cflag = 1;
    chk("brc.settle", {30'd0, dut.state_q}, {30'd0, ST_SETTLE});
    chk_out("brc.e0", 1, 0, 0, 16'h0000, 4'b0000);
    step();
    chk_out("brc.e1", 1, 0, 0, 16'h0000, 4'b0000);
    step();
    chk_out("brc.e2", 0, 1, 1, 16'h0105, 4'b0000);
    // SCF held off by a 3-cycle flag load
    req = 1; op = OP_SCF; srload_pending = 1;
    step();
    req = 0;
    chk_out("scf.hold0", 1, 0, 0, 16'h0105, 4'b0000);
    step();
    chk_out("scf.hold1", 1, 0, 0, 16'h0105, 4'b0000);
    step();
    chk_out("scf.hold2", 1, 0, 0, 16'h0105, 4'b0000);
    srload_pending = 0;
    step();
    chk_out("scf.strobe", 0, 1, 0, 16'h0105, 4'b0001);
    step();
    chk_out("scf.after", 0, 0, 0, 16'h0105, 4'b0000);
    // req while busy ignored; held req after ack starts CZF
    req = 1; op = OP_BRZ; pc = 16'h0020; offset = 8'h03; zflag = 0;
    step();
    op = OP_CZF;
    step();
    chk_out("busyreq.ack", 0, 1, 0, 16'h0021, 4'b0000);
    step();
    req = 0;
    chk_out("czf.e0", 1, 0, 0, 16'h0021, 4'b0000);
    step();
    chk_out("czf.strobe", 0, 1, 0, 16'h0021, 4'b1000);
    step();
    // reset in RESOLVE
    req = 1; op = OP_BRNZ; pc = 16'h0040; offset = 8'h04;
    step();
    req = 0; rst = 1;
    chk("rst_res.state", {30'd0, dut.state_q}, {30'd0, ST_RESOLVE});
    step();
    rst = 0;
    chk_out("rst_res", 0, 0, 0, 16'h0000, 4'b0000);
    step();
    chk_out("rst_res.after", 0, 0, 0, 16'h0000, 4'b0000);
    // reset in FLAG
    req = 1; op = OP_SZF; srload_pending = 1;
    step();
    req = 0; srload_pending = 0; rst = 1;
    chk("rst_flag.state", {30'd0, dut.state_q}, {30'd0, ST_FLAG});
    step();
    rst = 0;
    chk_out("rst_flag", 0, 0, 0, 16'h0000, 4'b0000);
    chk("rst_flag.idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    step();
    chk_out("rst_flag.after", 0, 0, 0, 16'h0000, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
